seg_scroll_ctrl: RTL

SEG_SCROLL_CTRL -- requirements
Module: seg_scroll_ctrl

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_hex_dec.sv | 11 +
 rtl/seg_scroll_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the scrolling hex display controller:
// FSM state encoding, blank pattern and the active-low hex-to-segment table.
package seg_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SCROLL = 1'b1
  } seg_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bits [6:0] = {a,b,c,d,e,f,g}, active low; entry 0 is the last element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Eight-digit scrolling hex message display with an append-only nibble buffer.
// Optional freeze input enabled by defining SEG_SCROLL_PAUSE_EN.
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int MSG_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [3:0] wr_data,
  output logic       wr_ready,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
`ifdef SEG_SCROLL_PAUSE_EN
  input  logic       pause,
`endif
  output logic       busy,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [6:0] seg5,
  output logic [6:0] seg6,
  output logic [6:0] seg7,
  output seg_state_e state_dbg
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [LW-1:0] DEPTH_L = LW'(MSG_DEPTH);
  localparam logic [CW-1:0] TERM    = CW'(TICK_DIV - 1);

  seg_state_e    state;
  logic [3:0]    mem [MSG_DEPTH];
  logic [LW-1:0] len;
  logic [AW-1:0] pos;
  logic [CW-1:0] cnt;
  logic          rdy_q;
  logic          busy_q;
  logic [6:0]    seg_q [8];
  logic          freeze;
  logic          wr_fire;
  logic [AW-1:0] idx [8];
  logic [3:0]    dig_hex [8];
  logic [6:0]    dec_seg [8];
  logic [LW-1:0] nxt;
  logic [LW-1:0] pos_inc;

`ifdef SEG_SCROLL_PAUSE_EN
  assign freeze = pause;
`else
  assign freeze = 1'b0;
`endif

  // Write handshake: a nibble transfers on a rising clk edge where wr_valid
  // and wr_ready are both high; wr_ready never depends on wr_valid.
  // rdy_q keeps ready low for the first cycle after reset is released.
  assign wr_ready = rdy_q && (state == ST_IDLE) && (len < DEPTH_L) && !clear;
  assign wr_fire  = wr_valid && wr_ready;
  assign pos_inc  = {1'b0, pos} + LW'(1);

  // Digit j shows buf[(pos+j) mod len]; each index is the previous one plus
  // one with a wrap at len, so short messages repeat without a divider.
  always_comb begin
    nxt = '0;
    idx[0] = pos;
    for (int j = 1; j < 8; j++) begin
      nxt    = {1'b0, idx[j-1]} + LW'(1);
      idx[j] = (nxt == len) ? '0 : nxt[AW-1:0];
    end
    for (int j = 0; j < 8; j++) begin
      dig_hex[j] = mem[idx[j]];
    end
  end

  for (genvar j = 0; j < 8; j++) begin : g_dec
    seg_hex_dec u_dec (
      .hex(dig_hex[j]),
      .seg(dec_seg[j])
    );
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[len[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      len    <= '0;
      pos    <= '0;
      cnt    <= '0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
      for (int d = 0; d < 8; d++) begin
        seg_q[d] <= SEG_BLANK;
      end
    end else begin
      rdy_q <= 1'b1;
      for (int j = 0; j < 8; j++) begin
        seg_q[7-j] <= (state == ST_SCROLL) ? dec_seg[j] : SEG_BLANK;
      end
      case (state)
        ST_IDLE: begin
          if (clear) begin
            len <= '0;
          end else if (wr_fire) begin
            len <= len + LW'(1);
          end
          if (start && (len != '0) && !clear) begin
            state  <= ST_SCROLL;
            busy_q <= 1'b1;
            pos    <= '0;
            cnt    <= '0;
          end
        end
        ST_SCROLL: begin
          if (stop) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (!freeze) begin
            if (cnt == TERM) begin
              cnt <= '0;
              pos <= (pos_inc == len) ? '0 : pos_inc[AW-1:0];
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign state_dbg = state;
  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];
  assign seg6 = seg_q[6];
  assign seg7 = seg_q[7];

endmodule
